// File: rtl/month_year_pkg.sv
// ============================================================================
// month_year_pkg : calendar limits and helpers shared by the month/year block
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

package month_year_pkg;

    localparam int unsigned MONTH_W = 4;
    localparam int unsigned YEAR_W  = 7;
    localparam int unsigned DATE_W  = 5;

    typedef logic [MONTH_W-1:0] month_t;
    typedef logic [YEAR_W-1:0]  year_t;
    typedef logic [DATE_W-1:0]  date_t;

    localparam month_t MONTH_MIN      = 4'd1;
    localparam month_t MONTH_MAX      = 4'd12;
    localparam year_t  YEAR_MIN       = 7'd0;
    localparam year_t  YEAR_MAX       = 7'd99;
    localparam date_t  DAYS_PER_MONTH = 5'd30;
    localparam date_t  DAY_FIRST      = 5'd1;

    function automatic logic month_valid(input month_t v);
        return (v >= MONTH_MIN) && (v <= MONTH_MAX);
    endfunction

    function automatic logic year_valid(input year_t v);
        return (v <= YEAR_MAX);
    endfunction

endpackage

`default_nettype wire

// File: rtl/month_year_wrap_counter.sv
// ============================================================================
// cal_wrap_counter : MIN..MAX counter with load priority and rollover pulse
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module cal_wrap_counter #(
    parameter int unsigned         WIDTH   = 4,
    parameter logic [WIDTH-1:0]    MIN_VAL = '0,
    parameter logic [WIDTH-1:0]    MAX_VAL = '1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] value,
    output logic             wrap
);

    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] value_d;

    always_comb begin
        value_d = value_q;
        wrap    = 1'b0;
        if (load) begin
            value_d = load_val;
        end else if (inc) begin
            if (value_q == MAX_VAL) begin
                value_d = MIN_VAL;
                wrap    = 1'b1;
            end else begin
                value_d = value_q + WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            value_q <= MIN_VAL;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

`default_nettype wire

// File: rtl/month_year.sv
// ============================================================================
// month_year : month/year calendar registers advanced by the day-of-month wrap
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module month_year
    import month_year_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic [4:0]   date,
    input  logic         load_month,
    input  logic         load_year,
    input  logic [6:0]   data,
    input  logic         enable,
    output logic [3:0]   month,
    output logic [6:0]   year,
    output logic [3:0]   month_bus,
    output logic [6:0]   year_bus,
    output logic         year_tick,
    output logic         load_err
);

    date_t  date_q,      date_d;
    logic   year_tick_q, year_tick_d;
    logic   load_err_q,  load_err_d;

    logic   month_tick;
    logic   month_ok,    year_ok;
    logic   month_ld,    year_ld;
    logic   month_inc,   year_inc;
    logic   month_wrap,  year_wrap;

    // Any asserted load request freezes its field against the tick, even when
    // the request itself is rejected; only a valid, lone request loads.
    always_comb begin
        date_d      = date;
        month_tick  = (date_q == DAYS_PER_MONTH) && (date == DAY_FIRST);
        month_ok    = month_valid(data[MONTH_W-1:0]);
        year_ok     = year_valid(data);
        month_ld    = load_month && !load_year && month_ok;
        year_ld     = load_year && !load_month && year_ok;
        month_inc   = month_tick && !load_month;
        year_inc    = month_wrap && !load_year;
        load_err_d  = (load_month && load_year)
                    || (load_month && !month_ok)
                    || (load_year && !year_ok);
        year_tick_d = year_inc || year_wrap;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            date_q      <= DAY_FIRST;
            year_tick_q <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            date_q      <= date_d;
            year_tick_q <= year_tick_d;
            load_err_q  <= load_err_d;
        end
    end

    cal_wrap_counter #(
        .WIDTH   (MONTH_W),
        .MIN_VAL (MONTH_MIN),
        .MAX_VAL (MONTH_MAX)
    ) u_month (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (month_inc),
        .load     (month_ld),
        .load_val (data[MONTH_W-1:0]),
        .value    (month),
        .wrap     (month_wrap)
    );

    cal_wrap_counter #(
        .WIDTH   (YEAR_W),
        .MIN_VAL (YEAR_MIN),
        .MAX_VAL (YEAR_MAX)
    ) u_year (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (year_inc),
        .load     (year_ld),
        .load_val (data),
        .value    (year),
        .wrap     (year_wrap)
    );

    assign year_tick = year_tick_q;
    assign load_err  = load_err_q;
    assign month_bus = enable ? month : '0;
    assign year_bus  = enable ? year  : '0;

endmodule

`default_nettype wire

// File: tb/tb_month_year.sv
// ============================================================================
// tb_month_year : directed vector table plus randomized run against a model
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_month_year;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] date;
    logic       load_month;
    logic       load_year;
    logic [6:0] data;
    logic       enable;
    logic [3:0] month;
    logic [6:0] year;
    logic [3:0] month_bus;
    logic [6:0] year_bus;
    logic       year_tick;
    logic       load_err;

    int n_vec  = 0;
    int n_fail = 0;

    month_year dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .date       (date),
        .load_month (load_month),
        .load_year  (load_year),
        .data       (data),
        .enable     (enable),
        .month      (month),
        .year       (year),
        .month_bus  (month_bus),
        .year_bus   (year_bus),
        .year_tick  (year_tick),
        .load_err   (load_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic [4:0] date;
        logic       lm;
        logic       ly;
        logic [6:0] data;
        logic       en;
        logic [3:0] m;
        logic [6:0] y;
        logic       t;
        logic       e;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input int d, input logic lm, input logic ly,
                       input int dat, input logic en, input int m, input int y,
                       input logic t, input logic e);
        vec_t v;
        v.rst_n = r;  v.date = 5'(d); v.lm = lm; v.ly = ly; v.data = 7'(dat);
        v.en = en;    v.m = 4'(m);    v.y = 7'(y); v.t = t;  v.e = e;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [7:0] act,
                       input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic apply(input logic r, input logic [4:0] d, input logic lm,
                         input logic ly, input logic [6:0] dat, input logic en);
        rst_n = r; date = d; load_month = lm; load_year = ly; data = dat; enable = en;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input int idx, input int m, input int y, input logic t,
                             input logic e, input logic en);
        chk("month",     idx, 8'(month),     8'(m));
        chk("year",      idx, 8'(year),      8'(y));
        chk("year_tick", idx, 8'(year_tick), 8'(t));
        chk("load_err",  idx, 8'(load_err),  8'(e));
        chk("month_bus", idx, 8'(month_bus), en ? 8'(m) : 8'd0);
        chk("year_bus",  idx, 8'(year_bus),  en ? 8'(y) : 8'd0);
    endtask

    // Reference model state
    int  mm, yy, dq;
    logic mt, me;

    task automatic model_step(input logic r, input int d, input logic lm,
                              input logic ly, input int dat);
        bit tick, carry, ok_m, ok_y;
        if (!r) begin
            mm = 1; yy = 0; dq = 1; mt = 0; me = 0;
            return;
        end
        tick  = (dq == 30) && (d == 1);
        ok_m  = ((dat % 16) >= 1) && ((dat % 16) <= 12);
        ok_y  = dat <= 99;
        carry = 0;
        me    = (lm && ly) || (lm && !ok_m) || (ly && !ok_y);
        if (lm) begin
            if (!ly && ok_m) mm = dat % 16;
        end else if (tick) begin
            carry = (mm == 12);
            mm    = (mm % 12) + 1;
        end
        mt = 0;
        if (ly) begin
            if (!lm && ok_y) yy = dat;
        end else if (carry) begin
            yy = (yy + 1) % 100;
            mt = 1;
        end
        dq = d;
    endtask

    initial begin
        logic [4:0] prev_d;
        rst_n = 1'b0; date = 5'd1; load_month = 1'b0; load_year = 1'b0;
        data = '0; enable = 1'b1;

        //    rst d  lm ly dat en  m  y   t e
        add(0, 1, 0, 0, 0,   1, 1, 0,  0, 0);
        add(1, 29,0, 0, 0,   1, 1, 0,  0, 0);
        add(1, 30,0, 0, 0,   1, 1, 0,  0, 0);
        add(1, 1, 0, 0, 0,   1, 2, 0,  0, 0);
        add(1, 2, 1, 0, 12,  1, 12,0,  0, 0);
        add(1, 30,0, 0, 0,   1, 12,0,  0, 0);
        add(1, 1, 0, 0, 0,   1, 1, 1,  1, 0);
        add(1, 2, 0, 0, 0,   1, 1, 1,  0, 0);
        add(1, 3, 0, 1, 99,  1, 1, 99, 0, 0);
        add(1, 4, 1, 0, 12,  1, 12,99, 0, 0);
        add(1, 30,0, 0, 0,   1, 12,99, 0, 0);
        add(1, 1, 0, 0, 0,   1, 1, 0,  1, 0);
        add(1, 2, 0, 0, 0,   1, 1, 0,  0, 0);
        add(1, 3, 1, 0, 13,  1, 1, 0,  0, 1);
        add(1, 4, 1, 0, 0,   1, 1, 0,  0, 1);
        add(1, 5, 0, 0, 0,   1, 1, 0,  0, 0);
        add(1, 6, 0, 1, 100, 1, 1, 0,  0, 1);
        add(1, 7, 1, 1, 5,   1, 1, 0,  0, 1);
        add(1, 8, 1, 0, 12,  1, 12,0,  0, 0);
        add(1, 30,0, 0, 0,   1, 12,0,  0, 0);
        add(1, 1, 1, 0, 5,   1, 5, 0,  0, 0);
        add(1, 2, 0, 0, 0,   0, 5, 0,  0, 0);
        add(1, 30,1, 0, 12,  1, 12,0,  0, 0);
        add(0, 1, 0, 0, 0,   1, 1, 0,  0, 0);
        add(1, 1, 0, 0, 0,   1, 1, 0,  0, 0);
        add(1, 31,0, 1, 42,  1, 1, 42, 0, 0);
        add(1, 1, 0, 0, 0,   1, 1, 42, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].rst_n, tbl[i].date, tbl[i].lm, tbl[i].ly, tbl[i].data, tbl[i].en);
            check_all(i, tbl[i].m, tbl[i].y, tbl[i].t, tbl[i].e, tbl[i].en);
        end

        // Randomized phase: start from reset, then track the model every cycle
        model_step(0, 1, 0, 0, 0);
        apply(0, 5'd1, 0, 0, 7'd0, 1);
        check_all(1000, mm, yy, mt, me, 1'b1);
        prev_d = 5'd1;
        for (int i = 0; i < 600; i++) begin
            logic       r, lm, ly, en;
            logic [4:0] d;
            logic [6:0] dat;
            int         sel;
            sel = $urandom_range(0, 9);
            if (sel <= 5)      d = (prev_d >= 5'd1 && prev_d < 5'd30) ? prev_d + 5'd1 : 5'd1;
            else if (sel == 6) d = 5'd30;
            else if (sel == 7) d = 5'd1;
            else if (sel == 8) d = 5'($urandom_range(0, 31));
            else               d = prev_d;
            prev_d = d;
            r   = ($urandom_range(0, 79) != 0);
            lm  = ($urandom_range(0, 9) == 0);
            ly  = ($urandom_range(0, 9) == 0);
            dat = ($urandom_range(0, 1) == 0) ? 7'($urandom_range(0, 127))
                                              : 7'($urandom_range(0, 14));
            en  = ($urandom_range(0, 3) != 0);
            model_step(r, int'(d), lm, ly, int'(dat));
            apply(r, d, lm, ly, dat, en);
            check_all(2000 + i, mm, yy, mt, me, en);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
